ps2_rx_frame_controller: RTL and testbench
==========================================

Name: ps2_rx_frame_controller

Overview:
- Sequences reception of PS/2 keyboard frames: 1 start, 8 data (LSB first), 1 odd-parity, 1 stop bit.
- Synchronises the external PS/2 clock and data lines and detects falling edges of the PS/2 clock.
- Shifts the frame in, runs the parity check, and delivers one scan code per frame with valid or error strobes.
- Sits between the PS/2 pins and the scan-code consumer. Also owns host inhibit: it drives the PS/2 clock low while reception is disabled.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages on ps2Clk and ps2Data (minimum 2).
- TIMEOUT_CYCLES, 50000, system clocks without a PS/2 falling edge before a partial frame is aborted. At 50 MHz this is 1 ms.

Ports:
- clk  in  1  system clock; everything is in this single domain.
- rst  in  1  synchronous, active-high reset.
- ps2Clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2Data  in  1  raw PS/2 data pin, asynchronous.
- rxEnable  in  1  1 = receive; 0 = inhibit device.
- ps2ClkDriveLow  out  1  open-drain control; 1 = pull the PS/2 clock low.
- scanCode  out  8  last correctly received byte.
- scanCodeValid  out  1  one-cycle strobe; scanCode updated in the same cycle.
- parityError  out  1  one-cycle strobe; frame dropped.
- frameError  out  1  one-cycle strobe; bad start/stop bit or timeout.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, bit counter=0, timeout counter=0, shift register=0.
- Output reset values: scanCode=8'h00, scanCodeValid=0, parityError=0, frameError=0, busy=0, ps2ClkDriveLow=0. Synchroniser flops reset to 1 (idle-high bus).
- Synchroniser and edge detect:
  - ps2Clk and ps2Data each pass through SYNC_STAGES flops, so the two lines stay aligned.
  - fallEdge = previous synced ps2Clk & ~current synced ps2Clk. It is one cycle wide.
  - All data sampling happens only in a fallEdge cycle.
  - Outputs are registered in that cycle, so pin-to-strobe latency is SYNC_STAGES+2 clk.
- States:
  - IDLE: on fallEdge with data=0, go to DATA with bitCnt=0. Data=1 at a falling edge is ignored and the block stays in IDLE.
  - DATA: on each fallEdge, shift = {data, shift[7:1]} and bitCnt++. At bitCnt==7, go to PARITY.
  - PARITY: on fallEdge, capture the parity bit and go to STOP.
  - STOP: on fallEdge, evaluate the frame and return to IDLE:
    - stop bit 0 → frameError. This takes priority; parity is not reported.
    - else parity bad → parityError.
    - else scanCode←shift and scanCodeValid=1.
- Parity rule: parity is OK when XOR(shift[7:0], parityBit)==1 (odd parity across 9 bits).
- scanCode holds its value across errors and idle periods.
- Timeout:
  - The counter clears on every fallEdge and in IDLE; it increments otherwise.
  - If the state is not IDLE and the counter reaches TIMEOUT_CYCLES-1: frameError strobe, go to IDLE, clear bitCnt.
- Enable:
  - rxEnable=0 forces state IDLE and clears the counters; no strobes are issued.
  - ps2ClkDriveLow = registered ~rxEnable (1-cycle latency).
  - Deasserting rxEnable mid-frame silently discards the frame.
- Simultaneity:
  - rst overrides everything.
  - rxEnable=0 overrides fallEdge and timeout.
  - At most one of the three strobes is high in any cycle.
- Reset mid-frame: the block returns to IDLE with no strobe. The next start bit begins a fresh frame.
- busy = (state != IDLE).

Decomposition:
- Shared package:
  - state enum {IDLE, DATA, PARITY, STOP}.
  - PS2_DATA_BITS=8.
  - Constants PS2_START_BIT=0 and PS2_STOP_BIT=1.
- One sub-module: ps2_parity_check. It is combinational: 8-bit data + parity bit in, parityOk out, odd parity.
- This module instantiates it on the shift register and the captured parity bit.

Test Plan:
- Frame 0x1C: start 0; data LSB-first 0,0,1,1,1,0,0,0; parity 0; stop 1. Expect scanCodeValid for exactly 1 cycle, SYNC_STAGES+2 clk after the 11th ps2Clk fall, with scanCode=8'h1C. No error strobes.
- Frame 0x1C with parity 1. Expect parityError for 1 cycle, scanCode stays 8'h1C, no valid strobe. Then frame 0xF0 with parity 1 → scanCode=8'hF0 and valid.
- Frame 0x1C with stop bit 0. Expect frameError only; scanCode unchanged.
- Stop ps2Clk after 5 data bits and idle for TIMEOUT_CYCLES clk. Expect frameError once and busy→0. A following clean 0x1C frame is received correctly.
- Assert rst for 1 cycle after 4 data bits. Expect all outputs at reset values and no strobes. A subsequent 0xF0 frame is received correctly.
- Drop rxEnable mid-frame. Expect ps2ClkDriveLow=1 one cycle later, busy=0, and no strobes. Re-enable, send 0x1C, expect valid.

Source files
------------

// File: rtl/ps2_rx_frame_controller_pkg.sv
// Shared types and constants for the PS/2 receive frame controller.
// A frame is 1 start, 8 data bits LSB first, 1 odd-parity bit and 1 stop bit.
package ps2_rx_frame_controller_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2State_t;

    localparam int   PS2_DATA_BITS = 8;
    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;

endpackage

// File: rtl/ps2_rx_frame_controller_parity_check.sv
// Odd-parity checker over a PS/2 data byte plus its parity bit.
// The frame is good when the nine bits together hold an odd number of ones.
module ps2_parity_check
    import ps2_rx_frame_controller_pkg::*;
(
    input  logic [PS2_DATA_BITS-1:0] data,
    input  logic                     parityBit,
    output logic                     parityOk
);

    assign parityOk = ^{data, parityBit};

endmodule

// File: rtl/ps2_rx_frame_controller.sv
// PS/2 keyboard receive controller: synchronises the pins, detects PS/2 clock
// falls, shifts in a frame and emits one scan code or error strobe per frame.
module ps2_rx_frame_controller
    import ps2_rx_frame_controller_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps2Clk,
    input  logic                     ps2Data,
    input  logic                     rxEnable,
    output logic                     ps2ClkDriveLow,
    output logic [PS2_DATA_BITS-1:0] scanCode,
    output logic                     scanCodeValid,
    output logic                     parityError,
    output logic                     frameError,
    output logic                     busy
);

    localparam int            TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0]   clkSync;
    logic [SYNC_STAGES-1:0]   dataSync;
    logic                     clkPrev;
    logic                     fallEdge;
    logic                     sampledData;

    ps2State_t                state;
    ps2State_t                stateNext;
    logic [2:0]               bitCnt;
    logic [2:0]               bitCntNext;
    logic [PS2_DATA_BITS-1:0] shiftReg;
    logic [PS2_DATA_BITS-1:0] shiftNext;
    logic                     parityBit;
    logic                     parityBitNext;
    logic [TW-1:0]            timeoutCnt;
    logic [TW-1:0]            timeoutNext;
    logic [PS2_DATA_BITS-1:0] scanCodeNext;
    logic                     validNext;
    logic                     parityErrNext;
    logic                     frameErrNext;
    logic                     parityOk;

    // Edge and data are registered together so the sampled bit always
    // belongs to the fall being acted on; this adds the second latency cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            clkSync     <= '1;
            dataSync    <= '1;
            clkPrev     <= 1'b1;
            fallEdge    <= 1'b0;
            sampledData <= 1'b1;
        end else begin
            clkSync     <= {clkSync[SYNC_STAGES-2:0], ps2Clk};
            dataSync    <= {dataSync[SYNC_STAGES-2:0], ps2Data};
            clkPrev     <= clkSync[SYNC_STAGES-1];
            fallEdge    <= clkPrev & ~clkSync[SYNC_STAGES-1];
            sampledData <= dataSync[SYNC_STAGES-1];
        end
    end

    ps2_parity_check parityCheck (
        .data      (shiftReg),
        .parityBit (parityBit),
        .parityOk  (parityOk)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bitCnt         <= '0;
            shiftReg       <= '0;
            parityBit      <= 1'b0;
            timeoutCnt     <= '0;
            scanCode       <= '0;
            scanCodeValid  <= 1'b0;
            parityError    <= 1'b0;
            frameError     <= 1'b0;
            ps2ClkDriveLow <= 1'b0;
        end else begin
            state          <= stateNext;
            bitCnt         <= bitCntNext;
            shiftReg       <= shiftNext;
            parityBit      <= parityBitNext;
            timeoutCnt     <= timeoutNext;
            scanCode       <= scanCodeNext;
            scanCodeValid  <= validNext;
            parityError    <= parityErrNext;
            frameError     <= frameErrNext;
            ps2ClkDriveLow <= ~rxEnable;
        end
    end

    // Priority: inhibit, then timeout, then the frame sequencing on a clock fall.
    always_comb begin
        stateNext     = state;
        bitCntNext    = bitCnt;
        shiftNext     = shiftReg;
        parityBitNext = parityBit;
        scanCodeNext  = scanCode;
        validNext     = 1'b0;
        parityErrNext = 1'b0;
        frameErrNext  = 1'b0;
        timeoutNext   = (state == IDLE || fallEdge) ? '0 : timeoutCnt + TW'(1);

        if (!rxEnable) begin
            stateNext   = IDLE;
            bitCntNext  = '0;
            timeoutNext = '0;
        end else if (state != IDLE && !fallEdge && timeoutCnt == TIMEOUT_LAST) begin
            stateNext    = IDLE;
            bitCntNext   = '0;
            timeoutNext  = '0;
            frameErrNext = 1'b1;
        end else if (fallEdge) begin
            case (state)
                IDLE: begin
                    if (sampledData == PS2_START_BIT) begin
                        stateNext  = DATA;
                        bitCntNext = '0;
                    end
                end
                DATA: begin
                    shiftNext  = {sampledData, shiftReg[PS2_DATA_BITS-1:1]};
                    bitCntNext = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        stateNext = PARITY;
                    end
                end
                PARITY: begin
                    parityBitNext = sampledData;
                    stateNext     = STOP;
                end
                STOP: begin
                    stateNext = IDLE;
                    if (sampledData != PS2_STOP_BIT) begin
                        frameErrNext = 1'b1;
                    end else if (!parityOk) begin
                        parityErrNext = 1'b1;
                    end else begin
                        scanCodeNext = shiftReg;
                        validNext    = 1'b1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_rx_frame_controller.sv
// Directed and randomized frames against a frame-level model of the receiver.
// Strobes are counted by a monitor and compared per frame.
module tb_ps2_rx_frame_controller;

    localparam int SYNC   = 2;
    localparam int TMO    = 200;
    localparam int LAT    = SYNC + 2;

    logic       clk;
    logic       rst;
    logic       ps2Clk;
    logic       ps2Data;
    logic       rxEnable;
    logic       ps2ClkDriveLow;
    logic [7:0] scanCode;
    logic       scanCodeValid;
    logic       parityError;
    logic       frameError;
    logic       busy;

    int asserts     = 0;
    int failures    = 0;
    int cycle       = 0;
    int validCnt    = 0;
    int parErrCnt   = 0;
    int frmErrCnt   = 0;
    int overlapCnt  = 0;
    int lastValidCy = 0;
    int fallCycle   = 0;
    logic [7:0] expScan;

    ps2_rx_frame_controller #(
        .SYNC_STAGES    (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ps2Clk         (ps2Clk),
        .ps2Data        (ps2Data),
        .rxEnable       (rxEnable),
        .ps2ClkDriveLow (ps2ClkDriveLow),
        .scanCode       (scanCode),
        .scanCodeValid  (scanCodeValid),
        .parityError    (parityError),
        .frameError     (frameError),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor sampling 1 ns after every rising edge.
    always @(posedge clk) begin
        cycle++;
        #1;
        if (scanCodeValid === 1'b1) begin
            validCnt++;
            lastValidCy = cycle;
        end
        if (parityError === 1'b1) parErrCnt++;
        if (frameError === 1'b1) frmErrCnt++;
        if ((32'(scanCodeValid === 1'b1) + 32'(parityError === 1'b1) + 32'(frameError === 1'b1)) > 1)
            overlapCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk);
        ps2Data = b;
        repeat (4) @(negedge clk);
        ps2Clk    = 1'b0;
        fallCycle = cycle;
        repeat (8) @(negedge clk);
        ps2Clk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Sends the first nBits of a frame: start, data LSB first, parity, stop.
    task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop, input int nBits);
        logic [10:0] frame;
        frame = {stop, par, data, 1'b0};
        for (int i = 0; i < nBits; i++) sendBit(frame[i]);
        ps2Data = 1'b1;
    endtask

    task automatic runFrame(input string tag, input logic [7:0] data, input logic par, input logic stop);
        int v0, p0, f0;
        int eV, eP, eF;
        v0 = validCnt; p0 = parErrCnt; f0 = frmErrCnt;
        eV = 0; eP = 0; eF = 0;
        if (stop == 1'b0) eF = 1;
        else if ((^{data, par}) != 1'b1) eP = 1;
        else begin
            eV = 1;
            expScan = data;
        end
        applyStimulus(data, par, stop, 11);
        repeat (10) @(negedge clk);
        checkOutput({tag, " valid"}, validCnt - v0, eV);
        checkOutput({tag, " parityError"}, parErrCnt - p0, eP);
        checkOutput({tag, " frameError"}, frmErrCnt - f0, eF);
        checkOutput({tag, " scanCode"}, scanCode, expScan);
        checkOutput({tag, " busy"}, busy, 1'b0);
        if (eV == 1) checkOutput({tag, " latency"}, lastValidCy - fallCycle, LAT);
    endtask

    initial begin
        int v0, p0, f0;
        rst      = 1'b1;
        ps2Clk   = 1'b1;
        ps2Data  = 1'b1;
        rxEnable = 1'b1;
        expScan  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset scanCode", scanCode, 8'h00);
        checkOutput("reset strobes", {scanCodeValid, parityError, frameError}, 3'b000);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset driveLow", ps2ClkDriveLow, 1'b0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] directed frames");
        runFrame("good 1C", 8'h1C, 1'b0, 1'b1);
        runFrame("parity 1C", 8'h1C, 1'b1, 1'b1);
        runFrame("good F0", 8'hF0, 1'b1, 1'b1);
        runFrame("stop0 1C", 8'h1C, 1'b0, 1'b0);

        // Partial frame then silence until the timeout fires.
        v0 = validCnt; p0 = parErrCnt; f0 = frmErrCnt;
        applyStimulus(8'h1C, 1'b0, 1'b1, 6);
        repeat (4) @(negedge clk);
        checkOutput("timeout busy mid", busy, 1'b1);
        repeat (TMO + 10) @(negedge clk);
        checkOutput("timeout frameError", frmErrCnt - f0, 1);
        checkOutput("timeout other", (validCnt - v0) + (parErrCnt - p0), 0);
        checkOutput("timeout busy", busy, 1'b0);
        runFrame("after timeout", 8'h1C, 1'b0, 1'b1);

        // Reset mid-frame.
        v0 = validCnt; p0 = parErrCnt; f0 = frmErrCnt;
        applyStimulus(8'h5A, 1'b1, 1'b1, 5);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        expScan = 8'h00;
        checkOutput("midreset scanCode", scanCode, 8'h00);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset driveLow", ps2ClkDriveLow, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("midreset strobes", (validCnt - v0) + (parErrCnt - p0) + (frmErrCnt - f0), 0);
        runFrame("after reset", 8'hF0, 1'b1, 1'b1);

        // Inhibit mid-frame.
        v0 = validCnt; p0 = parErrCnt; f0 = frmErrCnt;
        applyStimulus(8'h33, 1'b1, 1'b1, 4);
        rxEnable = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("inhibit driveLow", ps2ClkDriveLow, 1'b1);
        checkOutput("inhibit busy", busy, 1'b0);
        repeat (TMO + 10) @(negedge clk);
        checkOutput("inhibit strobes", (validCnt - v0) + (parErrCnt - p0) + (frmErrCnt - f0), 0);
        rxEnable = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reenable driveLow", ps2ClkDriveLow, 1'b0);
        runFrame("after enable", 8'h1C, 1'b0, 1'b1);

        $display("[TB] random frames");
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d = 8'($urandom);
            p = ~(^d);
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 4) != 0);
            runFrame($sformatf("rand%0d", n), d, p, s);
        end

        checkOutput("strobe overlap", overlapCnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
